// File: rtl/rtsnoc_echo_mc.sv
// rtsnoc_echo_mc: buffered multi-channel packet echo engine for one RTSNoC router.
// Each channel reads flits from its router port, rewrites the header so the packet
// returns to its sender, queues it in the egress FIFO and transmits it on the same
// channel (reflect) or on the next channel of the ring (ring).
module rtsnoc_echo_mc #(
    parameter int NUM_CH         = 2,
    parameter int LOCAL_X        = 0,
    parameter int LOCAL_Y        = 0,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16,
    parameter int FIFO_AW        = 2,
    localparam int SX            = SOC_SIZE_X,
    localparam int SY            = SOC_SIZE_Y,
    localparam int HDR           = 2 * SX + 2 * SY + 6,
    localparam int BUS           = NOC_DATA_WIDTH + HDR
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    mode_i,
    input  logic [NUM_CH*BUS-1:0]   dout_i,
    input  logic [NUM_CH-1:0]       nd_i,
    output logic [NUM_CH-1:0]       rd_o,
    output logic [NUM_CH*BUS-1:0]   din_o,
    output logic [NUM_CH-1:0]       wr_o,
    input  logic [NUM_CH-1:0]       wait_i,
    output logic [NUM_CH*16-1:0]    tx_cnt_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int OW    = SX + SY + 3;

    typedef enum logic [1:0] {IN_IDLE, IN_READ, IN_GAP} in_state_t;
    typedef enum logic {EG_IDLE, EG_SEND} eg_state_t;

    in_state_t        in_state   [NUM_CH];
    logic [2:0]       in_tgt     [NUM_CH];
    logic [2:0]       start_tgt  [NUM_CH];
    logic [NUM_CH-1:0] start_ok;

    eg_state_t        eg_state   [NUM_CH];

    logic [BUS-1:0]   mem        [NUM_CH][DEPTH];
    logic [CW-1:0]    wr_ptr     [NUM_CH];
    logic [CW-1:0]    rd_ptr     [NUM_CH];
    logic [CW-1:0]    fifo_count [NUM_CH];
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_open;

    logic [NUM_CH-1:0] push_en;
    logic [BUS-1:0]   push_data  [NUM_CH];

    logic             unused_dst;

    // Route each ingress in READ to its egress FIFO, building the echoed flit on the way
    always_comb begin
        for (int f = 0; f < NUM_CH; f++) begin
            push_en[f]   = 1'b0;
            push_data[f] = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_state[c] == IN_READ && in_tgt[c] == 3'(f)) begin
                    push_en[f]   = 1'b1;
                    push_data[f] = {SX'(LOCAL_X), SY'(LOCAL_Y), in_tgt[c],
                                    dout_i[c*BUS + NOC_DATA_WIDTH + OW +: OW],
                                    dout_i[c*BUS +: NOC_DATA_WIDTH]};
                end
            end
        end
    end

    // The incoming destination fields are overwritten by the echo and never needed
    always_comb begin
        unused_dst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            unused_dst = unused_dst ^ (^dout_i[c*BUS + NOC_DATA_WIDTH +: OW]);
        end
    end

    // FIFO occupancy; a slot about to be filled by a READ in flight is not offered again
    always_comb begin
        for (int f = 0; f < NUM_CH; f++) begin
            fifo_count[f] = wr_ptr[f] - rd_ptr[f];
            fifo_full[f]  = (fifo_count[f] == CW'(DEPTH));
            fifo_empty[f] = (fifo_count[f] == '0);
            fifo_open[f]  = !fifo_full[f] &&
                            !(push_en[f] && fifo_count[f] == CW'(DEPTH - 1));
        end
    end

    // Pick the egress for a new read from the current mode and check it has room
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            start_tgt[c] = mode_i ? 3'((c + 1) % NUM_CH) : 3'(c);
            start_ok[c]  = nd_i[c] && en_i &&
                           (mode_i ? fifo_open[(c + 1) % NUM_CH] : fifo_open[c]);
        end
    end

    // Ingress FSMs: IDLE -> READ (one cycle, rd_o high) -> GAP (one cycle) -> IDLE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_o <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                in_state[c] <= IN_IDLE;
                in_tgt[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (in_state[c])
                    IN_IDLE: begin
                        if (start_ok[c]) begin
                            in_state[c] <= IN_READ;
                            in_tgt[c]   <= start_tgt[c];
                            rd_o[c]     <= 1'b1;
                        end
                    end
                    IN_READ: begin
                        in_state[c] <= IN_GAP;
                        rd_o[c]     <= 1'b0;
                    end
                    IN_GAP: begin
                        in_state[c] <= IN_IDLE;
                    end
                    default: begin
                        in_state[c] <= IN_IDLE;
                        rd_o[c]     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Write pointers advance on every push
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int f = 0; f < NUM_CH; f++) begin
                wr_ptr[f] <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_CH; f++) begin
                if (push_en[f]) begin
                    wr_ptr[f] <= wr_ptr[f] + CW'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset: emptiness is tracked by the pointers alone
    always_ff @(posedge clk_i) begin
        for (int f = 0; f < NUM_CH; f++) begin
            if (push_en[f]) begin
                mem[f][wr_ptr[f][FIFO_AW-1:0]] <= push_data[f];
            end
        end
    end

    // Egress FSMs: pop into din_o, hold wr_o until the router takes it, count the transfer
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_o     <= '0;
            din_o    <= '0;
            tx_cnt_o <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                eg_state[c] <= EG_IDLE;
                rd_ptr[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (eg_state[c])
                    EG_IDLE: begin
                        if (!fifo_empty[c]) begin
                            din_o[c*BUS +: BUS] <= mem[c][rd_ptr[c][FIFO_AW-1:0]];
                            rd_ptr[c]           <= rd_ptr[c] + CW'(1);
                            wr_o[c]             <= 1'b1;
                            eg_state[c]         <= EG_SEND;
                        end
                    end
                    EG_SEND: begin
                        if (!wait_i[c]) begin
                            wr_o[c]               <= 1'b0;
                            tx_cnt_o[c*16 +: 16]  <= tx_cnt_o[c*16 +: 16] + 16'd1;
                            eg_state[c]           <= EG_IDLE;
                        end
                    end
                    default: begin
                        wr_o[c]     <= 1'b0;
                        eg_state[c] <= EG_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtsnoc_echo_mc.sv
// tb_rtsnoc_echo_mc: directed and randomized checks of the echo engine against a
// queue-based model of router traffic and expected echoed flits.
module tb_rtsnoc_echo_mc;

    localparam int NUM_CH  = 2;
    localparam int LOCAL_X = 0;
    localparam int LOCAL_Y = 0;
    localparam int SX      = 1;
    localparam int SY      = 1;
    localparam int DW      = 16;
    localparam int FIFO_AW = 2;
    localparam int OW      = SX + SY + 3;
    localparam int BUS     = DW + 2 * SX + 2 * SY + 6;

    logic                  clk_i  = 1'b0;
    logic                  rst_i  = 1'b0;
    logic                  en_i   = 1'b0;
    logic                  mode_i = 1'b0;
    logic [NUM_CH*BUS-1:0] dout_i = '0;
    logic [NUM_CH-1:0]     nd_i   = '0;
    logic [NUM_CH-1:0]     rd_o;
    logic [NUM_CH*BUS-1:0] din_o;
    logic [NUM_CH-1:0]     wr_o;
    logic [NUM_CH-1:0]     wait_i = '0;
    logic [NUM_CH*16-1:0]  tx_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [BUS-1:0]    src_q [NUM_CH][$];
    logic [BUS-1:0]    exp_q [NUM_CH][$];
    logic [15:0]       exp_cnt [NUM_CH];
    logic [NUM_CH-1:0] pop_pending = '0;
    logic              mode_seen = 1'b0;

    localparam logic [BUS-1:0] FLIT1 = {10'b10_010_00_000, 16'hA5A5};
    localparam logic [BUS-1:0] ECHO1 = {10'b00_000_10_010, 16'hA5A5};

    rtsnoc_echo_mc #(
        .NUM_CH(NUM_CH), .LOCAL_X(LOCAL_X), .LOCAL_Y(LOCAL_Y),
        .SOC_SIZE_X(SX), .SOC_SIZE_Y(SY), .NOC_DATA_WIDTH(DW), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
        .dout_i(dout_i), .nd_i(nd_i), .rd_o(rd_o), .din_o(din_o),
        .wr_o(wr_o), .wait_i(wait_i), .tx_cnt_o(tx_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Echoed flit: dst becomes the old orig, orig becomes this router plus egress index
    function automatic logic [BUS-1:0] echo_of(input logic [BUS-1:0] f, input int egress);
        logic [OW-1:0] orig;
        orig = f[BUS-1 -: OW];
        return {SX'(LOCAL_X), SY'(LOCAL_Y), 3'(egress), orig, f[DW-1:0]};
    endfunction

    function automatic logic [BUS-1:0] rand_flit();
        return BUS'($urandom());
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [BUS-1:0] flit);
        src_q[ch].push_back(flit);
    endtask

    // Router side: present queue heads, retire a flit after the edge that ends its READ
    always @(posedge clk_i) begin
        mode_seen = mode_i;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_pending[c]) begin
                if (src_q[c].size() > 0) src_q[c].delete(0);
                pop_pending[c] = 1'b0;
            end
            if (src_q[c].size() > 0) begin
                nd_i[c] = 1'b1;
                dout_i[c*BUS +: BUS] = src_q[c][0];
            end else begin
                nd_i[c] = 1'b0;
                dout_i[c*BUS +: BUS] = '0;
            end
        end
    end

    // Scoreboard: model where each read flit must reappear, check every accepted write
    always @(negedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_o[c]) begin
                if (src_q[c].size() == 0) begin
                    checkOutput($sformatf("rd_without_data_ch%0d", c), 64'(rd_o[c]), 64'd0);
                end else begin
                    int e;
                    e = mode_seen ? (c + 1) % NUM_CH : c;
                    exp_q[e].push_back(echo_of(src_q[c][0], e));
                    pop_pending[c] = 1'b1;
                end
            end
            if (wr_o[c]) begin
                if (exp_q[c].size() == 0) begin
                    checkOutput($sformatf("unexpected_wr_ch%0d", c), 64'(wr_o[c]), 64'd0);
                end else if (!wait_i[c]) begin
                    logic [BUS-1:0] want;
                    want = exp_q[c].pop_front();
                    checkOutput($sformatf("din_ch%0d", c), 64'(din_o[c*BUS +: BUS]), 64'(want));
                    exp_cnt[c] = exp_cnt[c] + 16'd1;
                end
            end
        end
    end

    task automatic waitDrain(input int max_cycles);
        int drained;
        drained = 0;
        for (int i = 0; i < max_cycles && drained == 0; i++) begin
            @(negedge clk_i);
            drained = 1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (src_q[c].size() != 0 || exp_q[c].size() != 0) drained = 0;
            end
            if (pop_pending != '0 || wr_o != '0) drained = 0;
        end
        @(negedge clk_i);
        checkOutput("drained", 64'(drained), 64'd1);
    endtask

    task automatic checkCounts(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            checkOutput($sformatf("%s_txcnt_ch%0d", tag, c), 64'(tx_cnt_o[c*16 +: 16]),
                        64'(exp_cnt[c]));
        end
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = 16'd0;

        // Reset values
        repeat (2) @(negedge clk_i);
        checkOutput("reset_rd", 64'(rd_o), 64'd0);
        checkOutput("reset_wr", 64'(wr_o), 64'd0);
        checkOutput("reset_din", 64'(din_o), 64'd0);
        checkOutput("reset_txcnt", 64'(tx_cnt_o), 64'd0);
        rst_i = 1'b1;
        en_i  = 1'b1;

        // Reflect: ch0 echo with latency and fixed header values
        begin : t_reflect
            int found;
            found = 0;
            applyStimulus(0, FLIT1);
            for (int i = 0; i < 20 && found == 0; i++) begin
                @(negedge clk_i);
                if (rd_o[0]) found = 1;
            end
            checkOutput("rd_seen", 64'(found), 64'd1);
            @(negedge clk_i);
            checkOutput("wr_not_early", 64'(wr_o[0]), 64'd0);
            @(negedge clk_i);
            checkOutput("wr_two_after_rd", 64'(wr_o[0]), 64'd1);
            checkOutput("echo_header", 64'(din_o[0 +: BUS]), 64'(ECHO1));
            waitDrain(50);
            checkOutput("reflect_txcnt0", 64'(tx_cnt_o[15:0]), 64'd1);
            checkOutput("reflect_txcnt1", 64'(tx_cnt_o[31:16]), 64'd0);
        end

        // Ring: flit on ch1 must leave on ch0
        @(posedge clk_i); #1;
        mode_i = 1'b1;
        applyStimulus(1, FLIT1);
        waitDrain(50);
        checkOutput("ring_txcnt0", 64'(tx_cnt_o[15:0]), 64'd2);
        checkOutput("ring_txcnt1", 64'(tx_cnt_o[31:16]), 64'd0);

        // Backpressure: 1 in SEND + 4 buffered, the sixth stays in the router
        @(posedge clk_i); #1;
        mode_i = 1'b0;
        wait_i[0] = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus(0, rand_flit());
        repeat (60) @(negedge clk_i);
        checkOutput("bp_left_in_router", 64'(src_q[0].size()), 64'd1);
        checkOutput("bp_outstanding", 64'(exp_q[0].size()), 64'd5);
        checkOutput("bp_wr_held", 64'(wr_o[0]), 64'd1);
        checkOutput("bp_held_flit", 64'(din_o[0 +: BUS]), 64'(exp_q[0][0]));
        begin : t_bp_hold
            int rd_seen;
            rd_seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_i);
                if (rd_o[0]) rd_seen++;
            end
            checkOutput("bp_no_rd_when_full", 64'(rd_seen), 64'd0);
        end
        @(posedge clk_i); #1;
        wait_i[0] = 1'b0;
        waitDrain(100);
        checkOutput("bp_txcnt0", 64'(tx_cnt_o[15:0]), 64'd8);

        // Mode switch mid-stream: two reflected, two ringed
        applyStimulus(0, rand_flit());
        applyStimulus(0, rand_flit());
        for (int i = 0; i < 40 && src_q[0].size() != 0; i++) @(negedge clk_i);
        @(posedge clk_i); #1;
        mode_i = 1'b1;
        applyStimulus(0, rand_flit());
        applyStimulus(0, rand_flit());
        waitDrain(100);
        checkOutput("switch_txcnt0", 64'(tx_cnt_o[15:0]), 64'd10);
        checkOutput("switch_txcnt1", 64'(tx_cnt_o[31:16]), 64'd2);

        // Enable low: no reads start, then the packet drains once enabled
        @(posedge clk_i); #1;
        mode_i = 1'b0;
        en_i   = 1'b0;
        applyStimulus(1, rand_flit());
        begin : t_enable
            int rd_seen;
            rd_seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk_i);
                if (rd_o != '0) rd_seen++;
            end
            checkOutput("en_low_no_rd", 64'(rd_seen), 64'd0);
        end
        @(posedge clk_i); #1;
        en_i = 1'b1;
        waitDrain(50);
        checkOutput("en_txcnt1", 64'(tx_cnt_o[31:16]), 64'd3);

        // Randomized traffic with random mode, enable and backpressure
        begin : t_random
            int offered;
            logic [15:0] base0, base1, delivered;
            offered = 0;
            base0 = exp_cnt[0];
            base1 = exp_cnt[1];
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_i); #2;
                for (int c = 0; c < NUM_CH; c++) begin
                    wait_i[c] = ($urandom_range(0, 3) == 0);
                    if (src_q[c].size() < 2 && $urandom_range(0, 2) == 0) begin
                        applyStimulus(c, rand_flit());
                        offered++;
                    end
                end
                if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
                en_i = ($urandom_range(0, 9) != 0);
            end
            @(posedge clk_i); #2;
            en_i   = 1'b1;
            wait_i = '0;
            waitDrain(800);
            delivered = (exp_cnt[0] - base0) + (exp_cnt[1] - base1);
            checkOutput("random_no_loss", 64'(delivered), 64'(offered));
            checkCounts("random");
        end

        // Counter wrap: preset ch0 to 0xFFFF, one more transfer wraps to 0
        @(negedge clk_i);
        force dut.tx_cnt_o = {exp_cnt[1], 16'hFFFF};
        #1;
        release dut.tx_cnt_o;
        exp_cnt[0] = 16'hFFFF;
        #1;
        checkOutput("wrap_preset", 64'(tx_cnt_o[15:0]), 64'hFFFF);
        @(posedge clk_i); #1;
        mode_i = 1'b0;
        applyStimulus(0, rand_flit());
        waitDrain(50);
        checkOutput("wrap_to_zero", 64'(tx_cnt_o[15:0]), 64'd0);
        checkCounts("wrap");

        // Asynchronous reset with a flit in SEND and three buffered
        @(posedge clk_i); #1;
        wait_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(0, rand_flit());
        for (int i = 0; i < 60 && !(exp_q[0].size() == 4 && src_q[0].size() == 0); i++)
            @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        checkOutput("pre_reset_wr", 64'(wr_o[0]), 64'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b0;
        #1;
        checkOutput("async_rst_wr", 64'(wr_o), 64'd0);
        checkOutput("async_rst_rd", 64'(rd_o), 64'd0);
        checkOutput("async_rst_din", 64'(din_o), 64'd0);
        checkOutput("async_rst_txcnt", 64'(tx_cnt_o), 64'd0);
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
            exp_cnt[c] = 16'd0;
        end
        pop_pending = '0;
        wait_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        begin : t_post_reset
            int wr_seen;
            wr_seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk_i);
                if (wr_o != '0) wr_seen++;
            end
            checkOutput("post_reset_no_wr", 64'(wr_seen), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
